// File: rtl/mux16_sel_reg_pkg.sv
// Shared widths for the 16:1 bit-selector leaf stage and the wider selectors built from it.
package mux16_sel_reg_pkg;

  // Number of select bits. Wider selectors stack leaves on top of this.
  localparam int MUX16_SEL_W = 4;

  // Number of candidate data bits in one leaf.
  localparam int MUX16_N = 1 << MUX16_SEL_W;

endpackage : mux16_sel_reg_pkg

// File: rtl/mux16_sel_reg_mux_2_1.sv
// 2:1 single-bit selector cell. This is the building block for the 16:1 tree.
// It is also instantiated on its own elsewhere.
module mux_2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic out
);

  // Pass a when sel is low and b when sel is high. The unselected input never reaches out.
  always_comb begin
    out = a;
    if (sel) begin
      out = b;
    end
  end

endmodule : mux_2_1

// File: rtl/mux16_sel_reg.sv
// 16:1 single-bit selector built as a balanced tree of 2:1 cells.
// It has a combinational output and a registered copy of that output.
// Two of these plus one mux_2_1 form a 32:1 register-file read-port bit slice.
module mux16_sel_reg
  import mux16_sel_reg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [MUX16_N-1:0]     in,
  input  logic [MUX16_SEL_W-1:0] sel,
  output logic                   out,
  output logic                   out_q
);

  // Intermediate results for each tree level. sel[0] steers the leaves and sel[3] steers the root.
  logic [7:0] lvl1;
  logic [3:0] lvl2;
  logic [1:0] lvl3;
  logic       lvl4;
  logic       out_d;

  // Level 1 pairs adjacent inputs (in[2i], in[2i+1]) under sel[0].
  for (genvar i = 0; i < 8; i++) begin : g_lvl1
    mux_2_1 u_mux (
      .a   (in[2*i]),
      .b   (in[2*i+1]),
      .sel (sel[0]),
      .out (lvl1[i])
    );
  end

  // Level 2 picks between pairs of level-1 results under sel[1].
  for (genvar i = 0; i < 4; i++) begin : g_lvl2
    mux_2_1 u_mux (
      .a   (lvl1[2*i]),
      .b   (lvl1[2*i+1]),
      .sel (sel[1]),
      .out (lvl2[i])
    );
  end

  // Level 3 picks between pairs of level-2 results under sel[2].
  for (genvar i = 0; i < 2; i++) begin : g_lvl3
    mux_2_1 u_mux (
      .a   (lvl2[2*i]),
      .b   (lvl2[2*i+1]),
      .sel (sel[2]),
      .out (lvl3[i])
    );
  end

  // Root cell under sel[3] chooses between the lower and upper halves of in.
  mux_2_1 u_root (
    .a   (lvl3[0]),
    .b   (lvl3[1]),
    .sel (sel[3]),
    .out (lvl4)
  );

  assign out = lvl4;

  // Next value of the registered copy is simply the current tree output.
  always_comb begin
    out_d = lvl4;
  end

  // Register the selected bit. Reset clears it immediately, independent of the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule : mux16_sel_reg

// File: tb/tb_mux16_sel_reg.sv
// Directed bench for the 16:1 bit selector and its registered copy.
// It also exercises the standalone 2:1 cell.
module tb_mux16_sel_reg;

  logic        clk;
  logic        reset;
  logic [15:0] tb_in;
  logic [3:0]  tb_sel;
  logic        tb_out;
  logic        tb_out_q;

  logic        c_a;
  logic        c_b;
  logic        c_sel;
  logic        c_out;

  int checks;
  int failures;

  // One directed vector with its hand-computed expected combinational result.
  typedef struct {
    logic [15:0] in;
    logic [3:0]  sel;
    logic        exp;
    string       name;
  } vec_t;

  vec_t vecs [0:15];

  mux16_sel_reg dut (
    .clk   (clk),
    .reset (reset),
    .in    (tb_in),
    .sel   (tb_sel),
    .out   (tb_out),
    .out_q (tb_out_q)
  );

  mux_2_1 u_cell (
    .a   (c_a),
    .b   (c_b),
    .sel (c_sel),
    .out (c_out)
  );

  // Free-running clock with a 10-unit period. Rising edges fall at 5, 15, 25, and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the selector inputs, then give the combinational path time to settle.
  task automatic applyStimulus(input logic [15:0] i, input logic [3:0] s);
    tb_in  = i;
    tb_sel = s;
    #1;
  endtask

  // Compare one observed bit against its expected value and tally the result.
  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [3:0]  s;
    bit          seen;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    tb_in    = 16'h0000;
    tb_sel   = 4'd0;
    c_a      = 1'b0;
    c_b      = 1'b0;
    c_sel    = 1'b0;

    // Directed table. Bit positions are worked out by hand from each hex pattern.
    vecs[0]  = '{16'h8001, 4'd0,  1'b1, "b8001_sel0"};
    vecs[1]  = '{16'h8001, 4'd15, 1'b1, "b8001_sel15"};
    vecs[2]  = '{16'h8001, 4'd7,  1'b0, "b8001_sel7"};
    vecs[3]  = '{16'hFFFF, 4'd9,  1'b1, "ones_sel9"};
    vecs[4]  = '{16'h0000, 4'd9,  1'b0, "zeros_sel9"};
    vecs[5]  = '{16'hA5A5, 4'd0,  1'b1, "a5a5_sel0"};
    vecs[6]  = '{16'hA5A5, 4'd1,  1'b0, "a5a5_sel1"};
    vecs[7]  = '{16'hA5A5, 4'd13, 1'b1, "a5a5_sel13"};
    vecs[8]  = '{16'h1234, 4'd4,  1'b1, "h1234_sel4"};
    vecs[9]  = '{16'h1234, 4'd3,  1'b0, "h1234_sel3"};
    vecs[10] = '{16'h1234, 4'd12, 1'b1, "h1234_sel12"};
    vecs[11] = '{16'h1234, 4'd13, 1'b0, "h1234_sel13"};
    vecs[12] = '{16'h7FFE, 4'd15, 1'b0, "h7ffe_sel15"};
    vecs[13] = '{16'h7FFE, 4'd0,  1'b0, "h7ffe_sel0"};
    vecs[14] = '{16'h7FFE, 4'd14, 1'b1, "h7ffe_sel14"};
    vecs[15] = '{16'h0400, 4'd10, 1'b1, "h0400_sel10"};

    // While reset is held, out_q must be 0 and out must still follow in[sel].
    applyStimulus(16'hA5A5, 4'd0);
    checkOutput("reset_out_q", tb_out_q, 1'b0);
    checkOutput("reset_out_comb", tb_out, 1'b1);

    // Table-driven combinational checks.
    for (int v = 0; v < 16; v++) begin
      applyStimulus(vecs[v].in, vecs[v].sel);
      checkOutput(vecs[v].name, tb_out, vecs[v].exp);
    end

    // All-zero and all-ones inputs must give a constant result for every select code.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(16'h0000, 4'(k));
      checkOutput("all_zero", tb_out, 1'b0);
      applyStimulus(16'hFFFF, 4'(k));
      checkOutput("all_ones", tb_out, 1'b1);
    end

    // Walking one. Only the addressed bit may influence out.
    for (int k = 0; k < 16; k++) begin
      s = 4'(k);
      applyStimulus(16'h0000, s);
      checkOutput("walk_clear0", tb_out, 1'b0);
      applyStimulus(16'h0001 << k, s);
      checkOutput("walk_set1", tb_out, 1'b1);
      applyStimulus(16'h0000, s);
      checkOutput("walk_clear1", tb_out, 1'b0);
      applyStimulus(16'h0001 << k, s);
      checkOutput("walk_set2", tb_out, 1'b1);
      for (int j = 0; j < 16; j++) begin
        if (j != k) begin
          applyStimulus(16'h0001 << j, s);
          checkOutput("walk_other_bit", tb_out, 1'b0);
          applyStimulus(~(16'h0001 << j), s);
          checkOutput("walk_other_clear", tb_out, 1'b1);
        end
      end
    end

    // Random patterns, checked against the bench's own bit-index model.
    for (int r = 0; r < 200; r++) begin
      pat = 16'($urandom);
      s   = 4'($urandom_range(0, 15));
      applyStimulus(pat, s);
      checkOutput("random", tb_out, pat[s]);
    end

    // Unknowns on unselected bits must not reach out.
    tb_in    = 16'bx;
    tb_in[5] = 1'b1;
    tb_sel   = 4'd5;
    #1;
    checkOutput("x_unselected_1", tb_out, 1'b1);
    tb_in[5] = 1'b0;
    #1;
    checkOutput("x_unselected_0", tb_out, 1'b0);

    // Standalone 2:1 cell over all eight input combinations.
    for (int i = 0; i < 8; i++) begin
      c_a   = i[0];
      c_b   = i[1];
      c_sel = i[2];
      #1;
      checkOutput("cell_2_1", c_out, i[2] ? i[1] : i[0]);
    end

    // Release reset between edges, then clock with in=FFFF and sel=3 until out_q rises.
    @(negedge clk);
    applyStimulus(16'hFFFF, 4'd3);
    reset = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (tb_out_q === 1'b1) seen = 1'b1;
    end
    checkOutput("reg_load_ones", tb_out_q, 1'b1);

    // Reset asserted mid-cycle must clear out_q with no clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_clear", tb_out_q, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", tb_out_q, 1'b0);
    end

    // Release reset. out_q stays 0 until the next rising edge captures in[sel].
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("release_no_edge", tb_out_q, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("release_first_edge", tb_out_q, 1'b1);

    // Latency: out follows the change at once, and out_q follows one edge later.
    @(negedge clk);
    applyStimulus(16'h0002, 4'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_base_out_q", tb_out_q, 1'b0);
    @(negedge clk);
    applyStimulus(16'h0002, 4'd1);
    checkOutput("lat_out_now", tb_out, 1'b1);
    checkOutput("lat_out_q_before", tb_out_q, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("lat_out_q_after", tb_out_q, 1'b1);

    // in and sel change together. Both outputs must track the new in[new sel].
    @(negedge clk);
    applyStimulus(16'h4000, 4'd14);
    checkOutput("both_change_out", tb_out, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("both_change_out_q", tb_out_q, 1'b1);
    @(negedge clk);
    applyStimulus(16'hBFFF, 4'd14);
    checkOutput("both_change_out0", tb_out, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("both_change_out_q0", tb_out_q, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux16_sel_reg
